mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS-subset CPU: addu, subu, ori, lw, sw, beq, lui, jal, jr.
- Sequences the shared datapath (PC/NPC, IR, GRF, ALU, EXT, DM) over FETCH/DECODE/EXE/MEM/WB states.
- Handshakes with wait-state instruction and data memories.
- Counts retired instructions for the test bench.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- Func  in  6  IR[5:0].
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- PCWrite  out  1  load PC from NPC.
- IRWrite  out  1  load IR from IM.
- RegWrite  out  1  GRF write enable.
- MemWrite  out  1  DM write enable.
- RegDst  out  3  000 rd, 001 rt, 010 $31.
- NPCop  out  3  000 PC+4, 001 beq (NPC applies zero flag), 010 jal target, 011 jr (rs).
- MemToReg  out  3  000 ALU, 001 DM data, 010 PC+4 of the current instruction.
- ALUSrc  out  3  000 rt data, 001 EXT output.
- Extop  out  2  00 zero-extend, 01 sign-extend, 10 lui shift.
- ALUop  out  2  00 add, 01 sub, 10 or.
- state  out  3  current state, for debug.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 are illegal and go to FETCH next cycle with no enables asserted.
- Reset: state=FETCH and instr_count=0. All enables are 0 during the reset cycle. Asserting reset mid-instruction aborts it with no PC, GRF or DM write.
- Select outputs are Moore outputs decoded from opcode/Func, using the encodings in Ports:
  - In FETCH, all selects are forced to 0.
  - From DECODE onward, selects hold their decoded values (IR is stable).
- FETCH: IRWrite = imem_ready. Go to DECODE when imem_ready, otherwise hold.
- DECODE:
  - jal: PCWrite=1, RegWrite=1 ($31 <- PC+4), then FETCH.
  - jr: PCWrite=1 with NPCop=011, then FETCH.
  - Unsupported opcode or Func: treated as a nop; PCWrite=1 with NPCop=000, then FETCH.
  - All other instructions go to EXE.
- EXE: the ALU computes.
  - beq: PCWrite=1 with NPCop=001, then FETCH.
  - lw, sw: go to MEM.
  - addu, subu, ori, lui: go to WB.
- MEM:
  - sw: MemWrite=1 is held until dmem_ready. PCWrite=1 in the dmem_ready cycle, then FETCH.
  - lw: wait for dmem_ready, then go to WB. No enables are asserted while waiting.
- WB: RegWrite=1 and PCWrite=1, then FETCH.
- Retirement: instr_count increments in every cycle where PCWrite=1, including nops. It never increments during a wait or under reset.
- Invariants:
  - Exactly one PCWrite per instruction.
  - RegWrite and MemWrite are never asserted together.
  - IRWrite is asserted only in FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - opcode/Func constants;
  - RegDst, NPCop, MemToReg, ALUSrc, Extop and ALUop encodings;
  - state codes;
  - an instruction-class enum: R_ALU, I_ALU, LOAD, STORE, BRANCH, JAL, JR, NOP.
- Sub-module mc_decode is purely combinational. It maps opcode/Func to the instruction class and the select values. It is instantiated once, and mc_ctrl contains the FSM, the enables and the counter.

Test Plan:
- addu with imem_ready=1 always -> states 0,1,2,4. RegDst=000, ALUop=00, RegWrite=1 and PCWrite=1 only in WB. instr_count 0->1.
- lw with dmem_ready low for 3 cycles -> MEM held 4 cycles with no enables, then WB with MemToReg=001 and RegDst=001. Total 8 cycles.
- sw with dmem_ready delayed 2 cycles -> MemWrite high for 3 cycles. PCWrite only in the last of them. RegWrite stays 0.
- jal then jr -> each takes 2 cycles. jal: RegDst=010, MemToReg=010, NPCop=010. jr: NPCop=011. instr_count +2.
- reset asserted in EXE of beq -> next state FETCH, no PCWrite, instr_count=0. opcode 6'b111111 -> nop retired in DECODE with NPCop=000.
- imem_ready low 5 cycles in FETCH -> IRWrite=0 throughout, state stays 0. IRWrite=1 on the first ready cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants, encodings and types for the multi-cycle MIPS-subset controller.
package mc_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

    localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;

    localparam logic [SEL_W-1:0] REGDST_RD   = 3'b000;
    localparam logic [SEL_W-1:0] REGDST_RT   = 3'b001;
    localparam logic [SEL_W-1:0] REGDST_RA   = 3'b010;

    localparam logic [SEL_W-1:0] NPC_PC4     = 3'b000;
    localparam logic [SEL_W-1:0] NPC_BEQ     = 3'b001;
    localparam logic [SEL_W-1:0] NPC_JAL     = 3'b010;
    localparam logic [SEL_W-1:0] NPC_JR      = 3'b011;

    localparam logic [SEL_W-1:0] M2R_ALU     = 3'b000;
    localparam logic [SEL_W-1:0] M2R_DM      = 3'b001;
    localparam logic [SEL_W-1:0] M2R_PC4     = 3'b010;

    localparam logic [SEL_W-1:0] ALUSRC_RT   = 3'b000;
    localparam logic [SEL_W-1:0] ALUSRC_EXT  = 3'b001;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        R_ALU, I_ALU, LOAD, STORE, BRANCH, JAL, JR, NOP
    } iclass_e;

    typedef struct packed {
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] npc_op;
        logic [SEL_W-1:0] mem_to_reg;
        logic [SEL_W-1:0] alu_src;
        logic [1:0]       ext_op;
        logic [1:0]       alu_op;
    } sel_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/Func to instruction class and datapath selects.
module mc_decode
    import mc_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] func,
    output iclass_e         iclass,
    output sel_t            sel
);

    always_comb begin
        iclass = NOP;
        sel    = '0;
        unique case (opcode)
            OP_RTYPE: begin
                if (func == FN_ADDU || func == FN_SUBU) begin
                    iclass     = R_ALU;
                    sel.alu_op = (func == FN_SUBU) ? ALU_SUB : ALU_ADD;
                end else if (func == FN_JR) begin
                    iclass     = JR;
                    sel.npc_op = NPC_JR;
                end
            end
            OP_ORI, OP_LUI: begin
                iclass      = I_ALU;
                sel.reg_dst = REGDST_RT;
                sel.alu_src = ALUSRC_EXT;
                sel.ext_op  = (opcode == OP_LUI) ? EXT_LUI : EXT_ZERO;
                sel.alu_op  = (opcode == OP_LUI) ? ALU_ADD : ALU_OR;
            end
            OP_LW: begin
                iclass         = LOAD;
                sel.reg_dst    = REGDST_RT;
                sel.mem_to_reg = M2R_DM;
                sel.alu_src    = ALUSRC_EXT;
                sel.ext_op     = EXT_SIGN;
                sel.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                iclass      = STORE;
                sel.alu_src = ALUSRC_EXT;
                sel.ext_op  = EXT_SIGN;
                sel.alu_op  = ALU_ADD;
            end
            OP_BEQ: begin
                iclass     = BRANCH;
                sel.npc_op = NPC_BEQ;
                sel.ext_op = EXT_SIGN;
                sel.alu_op = ALU_SUB;
            end
            OP_JAL: begin
                iclass         = JAL;
                sel.reg_dst    = REGDST_RA;
                sel.npc_op     = NPC_JAL;
                sel.mem_to_reg = M2R_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences the shared datapath, handshakes with memories, counts retirements.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  opcode,
    input  logic [OP_W-1:0]  Func,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [SEL_W-1:0] RegDst,
    output logic [SEL_W-1:0] NPCop,
    output logic [SEL_W-1:0] MemToReg,
    output logic [SEL_W-1:0] ALUSrc,
    output logic [1:0]       Extop,
    output logic [1:0]       ALUop,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_e  state_q;
    state_e  state_d;
    iclass_e iclass;
    sel_t    dec_sel;
    sel_t    sel;

    mc_decode u_decode (
        .opcode (opcode),
        .func   (Func),
        .iclass (iclass),
        .sel    (dec_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (PCWrite) instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next state and enables; reset masks every enable so an aborted instruction writes nothing.
    always_comb begin
        state_d  = S_FETCH;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                IRWrite = imem_ready;
                state_d = imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                unique case (iclass)
                    JAL: begin
                        PCWrite  = 1'b1;
                        RegWrite = 1'b1;
                    end
                    JR, NOP:  PCWrite = 1'b1;
                    default:  state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                unique case (iclass)
                    BRANCH:       PCWrite = 1'b1;
                    LOAD, STORE:  state_d = S_MEM;
                    R_ALU, I_ALU: state_d = S_WB;
                    default:      ;
                endcase
            end
            S_MEM: begin
                if (iclass == STORE) begin
                    MemWrite = 1'b1;
                    PCWrite  = dmem_ready;
                    state_d  = dmem_ready ? S_FETCH : S_MEM;
                end else if (iclass == LOAD) begin
                    state_d = dmem_ready ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    // Selects follow the decoded IR only while an instruction is in flight.
    always_comb begin
        sel = '0;
        if (state_q == S_DECODE || state_q == S_EXE || state_q == S_MEM || state_q == S_WB)
            sel = dec_sel;
    end

    assign RegDst   = sel.reg_dst;
    assign NPCop    = sel.npc_op;
    assign MemToReg = sel.mem_to_reg;
    assign ALUSrc   = sel.alu_src;
    assign Extop    = sel.ext_op;
    assign ALUop    = sel.alu_op;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-by-cycle directed trace of mc_ctrl against hand-computed expectations.
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  Func;
    logic        imem_ready;
    logic        dmem_ready;
    logic        PCWrite, IRWrite, RegWrite, MemWrite;
    logic [2:0]  RegDst, NPCop, MemToReg, ALUSrc;
    logic [1:0]  Extop, ALUop;
    logic [2:0]  state;
    logic [31:0] instr_count;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .Func        (Func),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .RegDst      (RegDst),
        .NPCop       (NPCop),
        .MemToReg    (MemToReg),
        .ALUSrc      (ALUSrc),
        .Extop       (Extop),
        .ALUop       (ALUop),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selects packed as {RegDst, NPCop, MemToReg, ALUSrc, Extop, ALUop}
    localparam logic [15:0] S_NONE = 16'h0000;
    localparam logic [15:0] S_ADDU = {3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00};
    localparam logic [15:0] S_SUBU = {3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 2'b01};
    localparam logic [15:0] S_ORI  = {3'b001, 3'b000, 3'b000, 3'b001, 2'b00, 2'b10};
    localparam logic [15:0] S_LW   = {3'b001, 3'b000, 3'b001, 3'b001, 2'b01, 2'b00};
    localparam logic [15:0] S_SW   = {3'b000, 3'b000, 3'b000, 3'b001, 2'b01, 2'b00};
    localparam logic [15:0] S_BEQ  = {3'b000, 3'b001, 3'b000, 3'b000, 2'b01, 2'b01};
    localparam logic [15:0] S_JAL  = {3'b010, 3'b010, 3'b010, 3'b000, 2'b00, 2'b00};
    localparam logic [15:0] S_JR   = {3'b000, 3'b011, 3'b000, 3'b000, 2'b00, 2'b00};

    // Enables packed as {PCWrite, IRWrite, RegWrite, MemWrite}
    localparam logic [3:0] E_NONE = 4'b0000;
    localparam logic [3:0] E_IR   = 4'b0100;
    localparam logic [3:0] E_PC   = 4'b1000;
    localparam logic [3:0] E_WB   = 4'b1010;
    localparam logic [3:0] E_MW   = 4'b0001;
    localparam logic [3:0] E_SWD  = 4'b1001;

    localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0d, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_JAL = 6'h03, OP_BAD = 6'h3f;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ir;
        logic        dr;
        logic [2:0]  st;
        logic [3:0]  en;
        logic [15:0] sel;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(logic rst, logic [5:0] op, logic [5:0] fn, logic ir, logic dr,
                                logic [2:0] st, logic [3:0] en, logic [15:0] sel, int cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.ir = ir; v.dr = dr;
        v.st = st; v.en = en; v.sel = sel; v.cnt = 32'(cnt);
        return v;
    endfunction

    function automatic logic [54:0] observed();
        return {state, PCWrite, IRWrite, RegWrite, MemWrite,
                RegDst, NPCop, MemToReg, ALUSrc, Extop, ALUop, instr_count};
    endfunction

    task automatic apply(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic ir, input logic dr);
        @(negedge clk);
        reset = rst; opcode = op; Func = fn; imem_ready = ir; dmem_ready = dr;
        #1;
    endtask

    task automatic check(input string name, input logic [54:0] act, input logic [54:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d en=%b sel=%h cnt=%0d, want st=%0d en=%b sel=%h cnt=%0d",
                     name, act[54:52], act[51:48], act[47:32], act[31:0],
                     exp[54:52], exp[51:48], exp[47:32], exp[31:0]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1; opcode = OP_R; Func = FN_ADDU; imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // reset cycle: nothing enabled even with imem_ready high
        vecs.push_back(mk(1, OP_R, FN_ADDU, 1, 0, 0, E_NONE, S_NONE, 0));
        // addu
        vecs.push_back(mk(0, OP_R, FN_ADDU, 1, 0, 0, E_IR,   S_NONE, 0));
        vecs.push_back(mk(0, OP_R, FN_ADDU, 1, 0, 1, E_NONE, S_ADDU, 0));
        vecs.push_back(mk(0, OP_R, FN_ADDU, 1, 0, 2, E_NONE, S_ADDU, 0));
        vecs.push_back(mk(0, OP_R, FN_ADDU, 1, 0, 4, E_WB,   S_ADDU, 0));
        // lw with three wait cycles
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 0, E_IR,   S_NONE, 1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 1, E_NONE, S_LW,   1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 2, E_NONE, S_LW,   1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 3, E_NONE, S_LW,   1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 3, E_NONE, S_LW,   1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 3, E_NONE, S_LW,   1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 1, 3, E_NONE, S_LW,   1));
        vecs.push_back(mk(0, OP_LW, 6'h00, 1, 0, 4, E_WB,   S_LW,   1));
        // sw with two wait cycles
        vecs.push_back(mk(0, OP_SW, 6'h00, 1, 0, 0, E_IR,   S_NONE, 2));
        vecs.push_back(mk(0, OP_SW, 6'h00, 1, 0, 1, E_NONE, S_SW,   2));
        vecs.push_back(mk(0, OP_SW, 6'h00, 1, 0, 2, E_NONE, S_SW,   2));
        vecs.push_back(mk(0, OP_SW, 6'h00, 1, 0, 3, E_MW,   S_SW,   2));
        vecs.push_back(mk(0, OP_SW, 6'h00, 1, 0, 3, E_MW,   S_SW,   2));
        vecs.push_back(mk(0, OP_SW, 6'h00, 1, 1, 3, E_SWD,  S_SW,   2));
        // jal then jr
        vecs.push_back(mk(0, OP_JAL, 6'h00, 1, 0, 0, E_IR,  S_NONE, 3));
        vecs.push_back(mk(0, OP_JAL, 6'h00, 1, 0, 1, E_WB,  S_JAL,  3));
        vecs.push_back(mk(0, OP_R,   FN_JR, 1, 0, 0, E_IR,  S_NONE, 4));
        vecs.push_back(mk(0, OP_R,   FN_JR, 1, 0, 1, E_PC,  S_JR,   4));
        // subu
        vecs.push_back(mk(0, OP_R, FN_SUBU, 1, 0, 0, E_IR,   S_NONE, 5));
        vecs.push_back(mk(0, OP_R, FN_SUBU, 1, 0, 1, E_NONE, S_SUBU, 5));
        vecs.push_back(mk(0, OP_R, FN_SUBU, 1, 0, 2, E_NONE, S_SUBU, 5));
        vecs.push_back(mk(0, OP_R, FN_SUBU, 1, 0, 4, E_WB,   S_SUBU, 5));
        // ori
        vecs.push_back(mk(0, OP_ORI, 6'h00, 1, 0, 0, E_IR,   S_NONE, 6));
        vecs.push_back(mk(0, OP_ORI, 6'h00, 1, 0, 1, E_NONE, S_ORI,  6));
        vecs.push_back(mk(0, OP_ORI, 6'h00, 1, 0, 2, E_NONE, S_ORI,  6));
        vecs.push_back(mk(0, OP_ORI, 6'h00, 1, 0, 4, E_WB,   S_ORI,  6));
        // beq aborted by reset in EXE, then re-run to completion
        vecs.push_back(mk(0, OP_BEQ, 6'h00, 1, 0, 0, E_IR,   S_NONE, 7));
        vecs.push_back(mk(0, OP_BEQ, 6'h00, 1, 0, 1, E_NONE, S_BEQ,  7));
        vecs.push_back(mk(1, OP_BEQ, 6'h00, 1, 0, 2, E_NONE, S_BEQ,  7));
        vecs.push_back(mk(0, OP_BEQ, 6'h00, 1, 0, 0, E_IR,   S_NONE, 0));
        vecs.push_back(mk(0, OP_BEQ, 6'h00, 1, 0, 1, E_NONE, S_BEQ,  0));
        vecs.push_back(mk(0, OP_BEQ, 6'h00, 1, 0, 2, E_PC,   S_BEQ,  0));
        // unsupported opcode retires as nop in DECODE
        vecs.push_back(mk(0, OP_BAD, 6'h00, 1, 0, 0, E_IR,   S_NONE, 1));
        vecs.push_back(mk(0, OP_BAD, 6'h00, 1, 0, 1, E_PC,   S_NONE, 1));
        // instruction memory stalls five cycles
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, OP_BAD, 6'h00, 0, 0, 0, E_NONE, S_NONE, 2));
        vecs.push_back(mk(0, OP_BAD, 6'h00, 1, 0, 0, E_IR,   S_NONE, 2));
        vecs.push_back(mk(0, OP_R,   6'h3f, 0, 0, 1, E_PC,   S_NONE, 2));
        vecs.push_back(mk(0, OP_R,   6'h3f, 0, 0, 0, E_NONE, S_NONE, 3));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].ir, vecs[i].dr);
            check($sformatf("vec%0d", i), observed(),
                  {vecs[i].st, vecs[i].en, vecs[i].sel, vecs[i].cnt});
        end

        // sw stalled in MEM, then reset: the store must be dropped and the count cleared
        apply(0, OP_SW, 6'h00, 1, 0);
        check("sw_abort_fetch", observed(), {3'd0, E_IR, S_NONE, 32'd3});
        apply(0, OP_SW, 6'h00, 1, 0);
        apply(0, OP_SW, 6'h00, 1, 0);
        apply(0, OP_SW, 6'h00, 1, 0);
        check("sw_abort_mem", observed(), {3'd3, E_MW, S_SW, 32'd3});
        apply(1, OP_SW, 6'h00, 1, 1);
        check("sw_abort_rst", observed(), {3'd3, E_NONE, S_SW, 32'd3});
        apply(0, OP_SW, 6'h00, 0, 1);
        check("sw_abort_after", observed(), {3'd0, E_NONE, S_NONE, 32'd0});

        // lui reaches WB through the immediate path with the shift extension
        apply(0, 6'h0f, 6'h00, 1, 0);
        apply(0, 6'h0f, 6'h00, 1, 0);
        check("lui_extop", {1'b0, Extop, ALUSrc, RegDst}, {1'b0, 2'b10, 3'b001, 3'b001});
        apply(0, 6'h0f, 6'h00, 1, 0);
        apply(0, 6'h0f, 6'h00, 1, 0);
        check("lui_wb", {state, PCWrite, RegWrite, MemWrite, instr_count},
              {3'd4, 1'b1, 1'b1, 1'b0, 32'd0});
        apply(0, 6'h0f, 6'h00, 0, 0);
        check("lui_count", {state, instr_count}, {3'd0, 32'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
